// File: rtl/osc_pkg.sv
// Shared types and constants for the oscillator sequencer: FSM state
// encoding, Q-format constants and the coefficient generator used to
// build the seed ROM at elaboration time.
package osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_RETUNE,
    ST_UPD
  } state_t;

  localparam int unsigned FRAC_BITS      = 29;
  // Oscillator amplitude A = 0.75 in Q2.29
  localparam logic signed [31:0] AMP_Q   = 32'sh1800_0000;
  localparam int unsigned LOCK_TICKS_DEF = 1024;
  localparam int unsigned PEND_IDX_RST   = 64;

  // Returns {A*sin(pi*k/128), 2*cos(pi*k/128)} in Q2.29 / Q3.29.
  // Angles are produced by the Chebyshev recurrence from the pi/128 step,
  // so no trig functions are needed during elaboration.
  function automatic logic [63:0] coef_entry(input int unsigned k);
    real c_step;
    real s_step;
    real c_prev;
    real c_cur;
    real s_prev;
    real s_cur;
    real c_next;
    real s_next;
    logic signed [31:0] i1;
    logic signed [31:0] i2;
    c_step = 0.99969881869620425;
    s_step = 0.02454122852291229;
    c_prev = 1.0;
    s_prev = 0.0;
    c_cur  = c_step;
    s_cur  = s_step;
    for (int unsigned i = 2; i <= k; i++) begin
      c_next = 2.0 * c_step * c_cur - c_prev;
      s_next = 2.0 * c_step * s_cur - s_prev;
      c_prev = c_cur;
      s_prev = s_cur;
      c_cur  = c_next;
      s_cur  = s_next;
    end
    if (k == 0) begin
      i1 = '0;
      i2 = '0;
    end else begin
      i1 = 32'(longint'(real'(AMP_Q) * s_cur));
      i2 = 32'(longint'(2.0 * c_cur * real'(longint'(1) << FRAC_BITS)));
    end
    return {i1, i2};
  endfunction

endpackage

// File: rtl/osc_seq_ctrl_if.sv
// Host command / oscillator control bundle for osc_seq_ctrl.
// The slave modport is the sequencer; the master modport is its driver.
interface osc_seq_ctrl_if #(
  parameter int unsigned IDX_W = 7,
  parameter int unsigned DIV_W = 16
);
  logic             start;
  logic             stop;
  logic             freq_wr;
  logic [IDX_W-1:0] freq_idx;
  logic [3:0]       mode_in;
  logic [DIV_W-1:0] div_ratio;
  logic             Ready;
  logic             Enable;
  logic             freqchange;
  logic [31:0]      init1;
  logic [31:0]      init2;
  logic [3:0]       Mode;
  logic             running;
  logic             wr_ack;
  logic             wr_err;

  modport master (
    output start, stop, freq_wr, freq_idx, mode_in, div_ratio,
    input  Ready, Enable, freqchange, init1, init2, Mode, running, wr_ack, wr_err
  );

  modport slave (
    input  start, stop, freq_wr, freq_idx, mode_in, div_ratio,
    output Ready, Enable, freqchange, init1, init2, Mode, running, wr_ack, wr_err
  );
endinterface

// File: rtl/osc_coef_rom.sv
// Synchronous seed-coefficient ROM: one-cycle read of {init1, init2}.
module osc_coef_rom
  import osc_pkg::*;
#(
  parameter int unsigned IDX_W = 7
) (
  input  logic             Fg_CLK,
  input  logic [IDX_W-1:0] addr,
  output logic [63:0]      data
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [63:0] tbl [DEPTH];
  logic [63:0] data_d;
  logic [63:0] data_q;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_entry
    localparam logic [63:0] ENTRY = coef_entry(k);
    assign tbl[k] = ENTRY;
  end

  // Table lookup for the addressed entry
  always_comb data_d = tbl[addr];

  // Registered read port
  always_ff @(posedge Fg_CLK) data_q <= data_d;

  assign data = data_q;
endmodule

// File: rtl/osc_seq_ctrl.sv
// Sequencer in front of the recursive sine oscillator: turns host
// start/stop/frequency writes into seed, sample-tick and retune controls.
module osc_seq_ctrl
  import osc_pkg::*;
#(
  parameter int unsigned IDX_W      = 7,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned LOCK_TICKS = LOCK_TICKS_DEF
) (
  input logic           Fg_CLK,
  input logic           RESETn,
  osc_seq_ctrl_if.slave bus
);
  localparam int unsigned LOCK_W = $clog2(LOCK_TICKS + 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic [3:0]        mode_q, mode_d;
  logic [31:0]       init1_q, init1_d;
  logic [31:0]       init2_q, init2_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic [63:0]       rom_data;
  logic              in_run;
  logic              tick;
  logic              idx_ok;

  assign in_run = (state_q == ST_RUN) || (state_q == ST_RETUNE) || (state_q == ST_UPD);
  assign tick   = in_run && (div_cnt_q >= bus.div_ratio);
  assign idx_ok = (bus.freq_idx != '0);

  // ROM is addressed with the next pend_idx so the entry is already on the
  // ROM output during LOAD/RETUNE and lands in init1/init2 one cycle later.
  osc_coef_rom #(.IDX_W(IDX_W)) u_rom (
    .Fg_CLK (Fg_CLK),
    .addr   (pend_idx_d),
    .data   (rom_data)
  );

  // Next-state, divider, lock counter and status pulse computation
  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    mode_d     = mode_q;
    init1_d    = init1_q;
    init2_d    = init2_q;
    div_cnt_d  = div_cnt_q;
    lock_d     = lock_q;
    wr_ack_d   = 1'b0;
    wr_err_d   = 1'b0;

    if (in_run) div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    if (tick && (lock_q != '0)) lock_d = lock_q - LOCK_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.freq_wr) begin
          if (idx_ok) begin
            pend_idx_d = bus.freq_idx;
            wr_ack_d   = 1'b1;
          end else begin
            wr_err_d = 1'b1;
          end
        end
        if (bus.start) begin
          mode_d  = bus.mode_in;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr_err_d = bus.freq_wr;
        init1_d  = rom_data[63:32];
        init2_d  = rom_data[31:0];
        state_d  = ST_ARM;
      end
      ST_ARM: begin
        wr_err_d  = bus.freq_wr;
        div_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (bus.freq_wr) begin
          if (idx_ok && (lock_q == '0)) begin
            pend_idx_d = bus.freq_idx;
            wr_ack_d   = 1'b1;
            state_d    = ST_RETUNE;
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
      ST_RETUNE: begin
        wr_err_d = bus.freq_wr;
        init1_d  = rom_data[63:32];
        init2_d  = rom_data[31:0];
        state_d  = ST_UPD;
      end
      ST_UPD: begin
        wr_err_d = bus.freq_wr;
        lock_d   = LOCK_W'(LOCK_TICKS);
        state_d  = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // stop overrides everything: coefficients, mode and pending index hold
    if (bus.stop) begin
      state_d   = ST_IDLE;
      mode_d    = mode_q;
      init1_d   = init1_q;
      init2_d   = init2_q;
      lock_d    = '0;
      div_cnt_d = '0;
      if (state_q != ST_IDLE) begin
        pend_idx_d = pend_idx_q;
        wr_ack_d   = 1'b0;
        wr_err_d   = bus.freq_wr;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= ST_IDLE;
      pend_idx_q <= IDX_W'(PEND_IDX_RST);
      mode_q     <= '0;
      init1_q    <= '0;
      init2_q    <= '0;
      div_cnt_q  <= '0;
      lock_q     <= '0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      mode_q     <= mode_d;
      init1_q    <= init1_d;
      init2_q    <= init2_d;
      div_cnt_q  <= div_cnt_d;
      lock_q     <= lock_d;
      wr_ack_q   <= wr_ack_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bus.Ready      = (state_q == ST_ARM) && !bus.stop;
  assign bus.Enable     = tick && !bus.stop;
  assign bus.freqchange = (state_q == ST_UPD) && !bus.stop;
  assign bus.init1      = init1_q;
  assign bus.init2      = init2_q;
  assign bus.Mode       = mode_q;
  assign bus.running    = in_run;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_err     = wr_err_q;
endmodule

// File: tb/tb_osc_seq_ctrl.sv
// Directed scoreboard bench for osc_seq_ctrl (LOCK_TICKS = 16, div_ratio = 3).
module tb_osc_seq_ctrl;

  typedef enum int {S_READY, S_ENABLE, S_FREQCH, S_INIT1, S_INIT2,
                    S_MODE, S_RUNNING, S_ACK, S_ERR} sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } item_t;

  localparam logic [31:0] I1_K64 = 32'h1800_0000;
  localparam logic [31:0] I2_K64 = 32'h0000_0000;
  localparam logic [31:0] I1_K32 = 32'h10F8_76CD;
  localparam logic [31:0] I2_K32 = 32'h2D41_3CCD;
  localparam logic [31:0] I1_K96 = 32'h10F8_76CD;
  localparam logic [31:0] I2_K96 = 32'hD2BE_C333;

  logic  Fg_CLK = 1'b0;
  logic  RESETn;
  item_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    ph     = 0;
  int    nt     = 0;

  always #5 Fg_CLK = ~Fg_CLK;

  osc_seq_ctrl_if #(.IDX_W(7), .DIV_W(16)) bus ();

  osc_seq_ctrl #(.IDX_W(7), .DIV_W(16), .LOCK_TICKS(16)) dut (
    .Fg_CLK (Fg_CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_READY:   return 32'(bus.Ready);
      S_ENABLE:  return 32'(bus.Enable);
      S_FREQCH:  return 32'(bus.freqchange);
      S_INIT1:   return bus.init1;
      S_INIT2:   return bus.init2;
      S_MODE:    return 32'(bus.Mode);
      S_RUNNING: return 32'(bus.running);
      S_ACK:     return 32'(bus.wr_ack);
      default:   return 32'(bus.wr_err);
    endcase
  endfunction

  task automatic push(input string tag, input sig_e sig, input logic [31:0] v);
    item_t it;
    it.tag = tag;
    it.sig = sig;
    it.exp = v;
    sbq.push_back(it);
  endtask

  task automatic drain();
    item_t       it;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      it  = sbq.pop_front();
      obs = observe(it.sig);
      checks++;
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge Fg_CLK);
    drain();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic push_all_zero(input string tag);
    push({tag, "_ready"}, S_READY, 0);
    push({tag, "_en"}, S_ENABLE, 0);
    push({tag, "_fc"}, S_FREQCH, 0);
    push({tag, "_i1"}, S_INIT1, 0);
    push({tag, "_i2"}, S_INIT2, 0);
    push({tag, "_mode"}, S_MODE, 0);
    push({tag, "_run"}, S_RUNNING, 0);
    push({tag, "_ack"}, S_ACK, 0);
    push({tag, "_err"}, S_ERR, 0);
  endtask

  // One cycle in RUN/RETUNE/UPD: Enable expected every 4th cycle from RUN entry
  task automatic run_cycle(input string tag);
    push({tag, "_en"}, S_ENABLE, 32'(ph == 3));
    push({tag, "_run"}, S_RUNNING, 1);
    push({tag, "_ready"}, S_READY, 0);
    if (ph == 3) nt++;
    ph = (ph + 1) % 4;
    next_cycle();
  endtask

  initial begin
    RESETn        = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.freq_wr   = 1'b0;
    bus.freq_idx  = '0;
    bus.mode_in   = '0;
    bus.div_ratio = 16'd3;

    push_all_zero("reset");
    next_cycle();
    RESETn = 1'b1;
    next_cycle();

    // k=0 write in IDLE is rejected
    bus.freq_wr  = 1'b1;
    bus.freq_idx = 7'd0;
    next_cycle();
    bus.freq_wr = 1'b0;
    push("idle_k0_err", S_ERR, 1);
    push("idle_k0_ack", S_ACK, 0);
    push("idle_k0_run", S_RUNNING, 0);
    next_cycle();

    // start at default pend_idx = 64
    bus.start   = 1'b1;
    bus.mode_in = 4'd5;
    push("start_ready", S_READY, 0);
    next_cycle();
    bus.start = 1'b0;
    push("load_mode", S_MODE, 5);
    push("load_ready", S_READY, 0);
    push("load_i1", S_INIT1, 0);
    next_cycle();
    push("arm_ready", S_READY, 1);
    push("arm_en", S_ENABLE, 0);
    push("arm_i1", S_INIT1, I1_K64);
    push("arm_i2", S_INIT2, I2_K64);
    push("arm_run", S_RUNNING, 0);
    next_cycle();
    ph = 0;
    for (int i = 0; i < 8; i++) run_cycle("run64");

    // k=0 write in RUN is rejected
    bus.freq_wr  = 1'b1;
    bus.freq_idx = 7'd0;
    run_cycle("run_k0");
    bus.freq_wr = 1'b0;
    push("run_k0_err", S_ERR, 1);
    push("run_k0_ack", S_ACK, 0);
    push("run_k0_i1", S_INIT1, I1_K64);
    run_cycle("run_k0b");

    // retune to k=32 with lock clear
    bus.freq_wr  = 1'b1;
    bus.freq_idx = 7'd32;
    run_cycle("rt32_wr");
    bus.freq_wr = 1'b0;
    push("rt32_ack", S_ACK, 1);
    push("rt32_fc0", S_FREQCH, 0);
    push("rt32_i1_old", S_INIT1, I1_K64);
    run_cycle("rt32_retune");
    push("rt32_fc", S_FREQCH, 1);
    push("rt32_i1", S_INIT1, I1_K32);
    push("rt32_i2", S_INIT2, I2_K32);
    run_cycle("rt32_upd");
    nt = 0;
    push("rt32_fc_end", S_FREQCH, 0);
    run_cycle("rt32_post");

    // write 10 ticks after retune is locked out
    while (nt < 10) run_cycle("lock_wait");
    bus.freq_wr  = 1'b1;
    bus.freq_idx = 7'd96;
    run_cycle("lock_wr");
    bus.freq_wr = 1'b0;
    push("lock_err", S_ERR, 1);
    push("lock_ack", S_ACK, 0);
    push("lock_i1", S_INIT1, I1_K32);
    push("lock_i2", S_INIT2, I2_K32);
    run_cycle("lock_chk");
    push("lock_fc", S_FREQCH, 0);
    run_cycle("lock_chk2");

    // 16th tick cycle: lock still 1; the cycle after it: lock 0
    while (nt < 15) run_cycle("lock_wait2");
    while (ph != 3) run_cycle("lock_align");
    bus.freq_wr  = 1'b1;
    bus.freq_idx = 7'd96;
    run_cycle("edge_wr1");
    push("edge_err", S_ERR, 1);
    push("edge_ack0", S_ACK, 0);
    run_cycle("edge_wr2");
    bus.freq_wr = 1'b0;
    push("unlock_ack", S_ACK, 1);
    push("unlock_err", S_ERR, 0);
    run_cycle("unlock_retune");
    push("k96_fc", S_FREQCH, 1);
    push("k96_i1", S_INIT1, I1_K96);
    push("k96_i2", S_INIT2, I2_K96);
    run_cycle("k96_upd");
    run_cycle("k96_post");

    // stop during RUN
    bus.stop = 1'b1;
    push("stop_run_now", S_RUNNING, 1);
    next_cycle();
    bus.stop = 1'b0;
    push("stop_en", S_ENABLE, 0);
    push("stop_run", S_RUNNING, 0);
    push("stop_ready", S_READY, 0);
    push("stop_i1", S_INIT1, I1_K96);
    push("stop_i2", S_INIT2, I2_K96);
    push("stop_mode", S_MODE, 5);
    next_cycle();

    // start together with stop in IDLE is ignored
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    bus.mode_in = 4'd9;
    next_cycle();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    push("ss_run", S_RUNNING, 0);
    push("ss_mode", S_MODE, 5);
    push("ss_ready", S_READY, 0);
    next_cycle();
    push("ss_ready2", S_READY, 0);
    push("ss_run2", S_RUNNING, 0);
    next_cycle();

    // restart from pend_idx=96, retune, then reset during RETUNE
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    push("rs_mode", S_MODE, 9);
    next_cycle();
    push("rs_ready", S_READY, 1);
    push("rs_i1", S_INIT1, I1_K96);
    push("rs_i2", S_INIT2, I2_K96);
    next_cycle();
    bus.freq_wr  = 1'b1;
    bus.freq_idx = 7'd32;
    push("rs_run", S_RUNNING, 1);
    next_cycle();
    bus.freq_wr = 1'b0;
    #2;
    push("rst_pre_ack", S_ACK, 1);
    push("rst_pre_run", S_RUNNING, 1);
    drain();
    RESETn = 1'b0;
    #1;
    push_all_zero("async_rst");
    drain();
    next_cycle();
    RESETn = 1'b1;
    next_cycle();

    // re-start uses the reset pend_idx of 64
    bus.start   = 1'b1;
    bus.mode_in = 4'd3;
    next_cycle();
    bus.start = 1'b0;
    next_cycle();
    push("post_rst_ready", S_READY, 1);
    push("post_rst_i1", S_INIT1, I1_K64);
    push("post_rst_i2", S_INIT2, I2_K64);
    push("post_rst_mode", S_MODE, 3);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
